pcd8544_rx_model: RTL
=====================

Name: pcd8544_rx_model

Overview:
- SPI responder for the 84x48 PCD8544-class LCD link, which is driven by the pet display FSM through spi_master.
- Samples mosi/sclk/ce/dc/lcd_rst and assembles bytes.
- Decodes the command set, and writes data bytes into an internal 504-byte display RAM with cursor auto-increment.
- Provides a read port so the host or testbench can inspect the rendered frame; used for on-board loopback checking and simulation.

Parameters:
- SYNC_STAGES, 2, flops per synchronizer on sclk/ce/mosi/dc/lcd_rst (min 2).
- COLS, 84, columns (X range 0..COLS-1).
- BANKS, 6, 8-pixel row banks (Y range 0..BANKS-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master, idle low, mosi sampled on rising edge.
- mosi  in  1  serial data, MSB first.
- ce  in  1  chip enable, active low.
- dc  in  1  0 = command, 1 = data; sampled with the 8th bit.
- lcd_rst  in  1  LCD reset from master, active low.
- rd_addr  in  9  RAM read address (Y*COLS+X).
- rd_data  out  8  RAM read data, 1-cycle latency.
- byte_valid  out  1  one-cycle pulse per received byte.
- rx_byte  out  8  last received byte.
- rx_dc  out  1  dc of last byte.
- cur_x  out  7  current X pointer.
- cur_y  out  3  current Y pointer.
- ext_mode  out  1  H bit (extended instruction set).
- vert_mode  out  1  V bit (vertical addressing).
- power_down  out  1  PD bit.
- disp_mode  out  2  {D,E} display control bits.
- vop  out  7  contrast value.

Behaviour:
- Reset (reset=0, async): all outputs 0 except power_down=1. Shift register, bit count and cursor cleared. RAM contents undefined (not cleared).
- lcd_rst low after synchronization: same register clear as reset, applied synchronously. Bytes are ignored while lcd_rst is low.
- Inputs pass through SYNC_STAGES flops. An sclk rising edge is detected from synced samples. Requires sclk high and low phases each >= SYNC_STAGES+1 clk.
- ce high (synced):
  - bit count forced to 0
  - partial byte discarded, no byte_valid pulse
  - ce may drop between bytes or stay low across bytes.
- On each sclk rise with ce low: shift mosi into the LSB. On the 8th bit, the byte is complete.
  - Next clk: byte_valid=1 for 1 cycle, rx_byte/rx_dc updated, command/data executed in that same cycle. Registers update 2 clk after the edge is detected.
- Command decode when dc=0, using H before the byte:
  - 0x20..0x27 (any H): PD=b2, V=b1, H=b0.
  - H=0, 0x08/0x09/0x0C/0x0D: disp_mode={b2,b0}.
  - H=0, 0x40..0x47: Y=b2:0 if < BANKS, else ignored.
  - H=0, 0x80..0xFF: X=b6:0 if < COLS, else ignored.
  - H=1, 0x80..0xFF: vop=b6:0. 0x04..0x07 (temp coeff) and 0x10..0x17 (bias) are accepted with no output.
  - All other bytes, including NOP 0x00: no effect.
- Data write when dc=1: ram[Y*COLS+X] <= byte in the execute cycle, then the pointer advances.
  - V=0: X+1; at X=COLS-1, X=0 and Y+1; at Y=BANKS-1, Y wraps to 0.
  - V=1: Y+1; at Y=BANKS-1, Y=0 and X+1; at X=COLS-1, X wraps to 0.
  - Data is written regardless of PD.
- Read port: synchronous read. rd_addr >= COLS*BANKS returns 0x00. Same-cycle read/write to one address returns the old data.
- Reset asserted mid-byte: byte lost, no pulse. Cursor returns to (0,0) after release.

Optional Feature:
- Macro PCD8544_RX_ERRCHK_EN.
- With the macro defined, adds two outputs:
  - err_frame (1): sticky, set when ce rises with bit count 1..7.
  - err_cmd (1): sticky, set on an out-of-range X/Y command or an undefined command byte.
  - Both are cleared by reset or lcd_rst.
- Without the macro: ports absent, no error logic.

Test Plan:
- Init: send cmd 0x21,0x90,0x20,0x0C,0x80 -> after the last byte: ext_mode=0, vop=0x10, disp_mode=2'b10, power_down=0, cur_x=0, 5 byte_valid pulses.
- Draw: cmd 0xA0,0x42 then data 0x0E,0x11,0x60,0x84 -> ram[200..203]=0E,11,60,84, cur_x=36, cur_y=2.
- Horizontal wrap: cmd 0xD3,0x45 (X=83, Y=5), data 0xAA,0x55 -> ram[503]=0xAA, ram[0]=0x55, cursor (1,0).
- Vertical mode: cmd 0x22,0x80,0x45, data 0x01,0x02 -> ram[420]=0x01, ram[0+1]=0x02 (X=1, Y=0), vert_mode=1.
- Abort/range: 5 bits then ce high, then cmd 0xE0 (X=96) -> no pulse for the partial byte, cur_x unchanged. With PCD8544_RX_ERRCHK_EN: err_frame=1, err_cmd=1.
- lcd_rst low for 20 clk mid-byte after cursor (10,3) -> cursor (0,0), power_down=1, next full byte decoded correctly.

Source files
------------

// File: rtl/pcd8544_rx_model.sv
// Behavioural SPI responder for a PCD8544-class 84x48 LCD: byte assembly, command decode, display RAM.
// Optional PCD8544_RX_ERRCHK_EN adds sticky err_frame / err_cmd outputs.
module pcd8544_rx_model #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COLS        = 84,
   parameter int unsigned BANKS       = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       ce,
   input  logic       dc,
   input  logic       lcd_rst,
   input  logic [8:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       rx_dc,
   output logic [6:0] cur_x,
   output logic [2:0] cur_y,
   output logic       ext_mode,
   output logic       vert_mode,
   output logic       power_down,
   output logic [1:0] disp_mode,
   output logic [6:0] vop
`ifdef PCD8544_RX_ERRCHK_EN
   ,
   output logic       err_frame,
   output logic       err_cmd
`endif
);

   localparam int unsigned DEPTH  = COLS * BANKS;
   localparam logic [6:0]  X_LAST = 7'(COLS - 1);
   localparam logic [2:0]  Y_LAST = 3'(BANKS - 1);

   logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, ce_sr, dc_sr, rst_sr;
   logic sclk_s, mosi_s, ce_s, dc_s, rst_s;

   // Input synchronizers; ce idles inactive (high)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sr <= '0;
         mosi_sr <= '0;
         ce_sr   <= '1;
         dc_sr   <= '0;
         rst_sr  <= '0;
      end else begin
         sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         ce_sr   <= {ce_sr[SYNC_STAGES-2:0], ce};
         dc_sr   <= {dc_sr[SYNC_STAGES-2:0], dc};
         rst_sr  <= {rst_sr[SYNC_STAGES-2:0], lcd_rst};
      end
   end

   assign sclk_s = sclk_sr[SYNC_STAGES-1];
   assign mosi_s = mosi_sr[SYNC_STAGES-1];
   assign ce_s   = ce_sr[SYNC_STAGES-1];
   assign dc_s   = dc_sr[SYNC_STAGES-1];
   assign rst_s  = rst_sr[SYNC_STAGES-1];

   logic       sclk_q;
   logic [6:0] shreg;
   logic [2:0] bit_cnt;
   logic       pend, pend_dc;
   logic [7:0] pend_byte;
   logic [7:0] ram [DEPTH];

   logic       rise_c, we_c;
   logic       is_func_c, is_disp_c, is_y_c, is_x_c, is_vop_c, y_ok_c, x_ok_c;
   logic [6:0] nx_x_c;
   logic [2:0] nx_y_c;
   logic [8:0] wr_addr_c;

   assign rise_c    = sclk_s & ~sclk_q;
   assign we_c      = pend & pend_dc & rst_s;
   assign wr_addr_c = 9'(cur_y) * 9'(COLS) + 9'(cur_x);

   // Command classification of the pending byte, using H as it stood before the byte
   always_comb begin
      is_func_c = (pend_byte[7:3] == 5'b00100);
      is_disp_c = !ext_mode && (pend_byte[7:3] == 5'b00001) && !pend_byte[1];
      is_y_c    = !ext_mode && (pend_byte[7:3] == 5'b01000);
      is_x_c    = !ext_mode && pend_byte[7];
      is_vop_c  = ext_mode && pend_byte[7];
      y_ok_c    = (32'(pend_byte[2:0]) < BANKS);
      x_ok_c    = (32'(pend_byte[6:0]) < COLS);
   end

   // Cursor advance after a data write
   always_comb begin
      nx_x_c = cur_x;
      nx_y_c = cur_y;
      if (!vert_mode) begin
         if (cur_x == X_LAST) begin
            nx_x_c = '0;
            nx_y_c = (cur_y == Y_LAST) ? 3'd0 : cur_y + 3'd1;
         end else begin
            nx_x_c = cur_x + 7'd1;
         end
      end else begin
         if (cur_y == Y_LAST) begin
            nx_y_c = '0;
            nx_x_c = (cur_x == X_LAST) ? 7'd0 : cur_x + 7'd1;
         end else begin
            nx_y_c = cur_y + 3'd1;
         end
      end
   end

`ifdef PCD8544_RX_ERRCHK_EN
   logic is_ext_nop_c, undef_c;
   always_comb begin
      is_ext_nop_c = ext_mode && ((pend_byte[7:2] == 6'b000001) || (pend_byte[7:3] == 5'b00010));
      undef_c      = !(is_func_c || is_disp_c || is_y_c || is_x_c || is_vop_c ||
                       is_ext_nop_c || (pend_byte == 8'h00));
   end
`endif

   // Byte assembly and execute stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_q     <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         pend       <= 1'b0;
         pend_dc    <= 1'b0;
         pend_byte  <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
         rx_dc      <= 1'b0;
         cur_x      <= '0;
         cur_y      <= '0;
         ext_mode   <= 1'b0;
         vert_mode  <= 1'b0;
         power_down <= 1'b1;
         disp_mode  <= '0;
         vop        <= '0;
`ifdef PCD8544_RX_ERRCHK_EN
         err_frame  <= 1'b0;
         err_cmd    <= 1'b0;
`endif
      end else begin
         sclk_q     <= sclk_s;
         byte_valid <= 1'b0;
         if (!rst_s) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            pend       <= 1'b0;
            pend_dc    <= 1'b0;
            pend_byte  <= '0;
            rx_byte    <= '0;
            rx_dc      <= 1'b0;
            cur_x      <= '0;
            cur_y      <= '0;
            ext_mode   <= 1'b0;
            vert_mode  <= 1'b0;
            power_down <= 1'b1;
            disp_mode  <= '0;
            vop        <= '0;
`ifdef PCD8544_RX_ERRCHK_EN
            err_frame  <= 1'b0;
            err_cmd    <= 1'b0;
`endif
         end else begin
            pend <= 1'b0;
            if (ce_s) begin
               bit_cnt <= '0;
`ifdef PCD8544_RX_ERRCHK_EN
               if (bit_cnt != 3'd0) err_frame <= 1'b1;
`endif
            end else if (rise_c) begin
               shreg   <= {shreg[5:0], mosi_s};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  pend      <= 1'b1;
                  pend_byte <= {shreg, mosi_s};
                  pend_dc   <= dc_s;
               end
            end

            if (pend) begin
               byte_valid <= 1'b1;
               rx_byte    <= pend_byte;
               rx_dc      <= pend_dc;
               if (pend_dc) begin
                  cur_x <= nx_x_c;
                  cur_y <= nx_y_c;
               end else begin
                  if (is_func_c) {power_down, vert_mode, ext_mode} <= pend_byte[2:0];
                  if (is_disp_c) disp_mode <= {pend_byte[2], pend_byte[0]};
                  if (is_y_c && y_ok_c) cur_y <= pend_byte[2:0];
                  if (is_x_c && x_ok_c) cur_x <= pend_byte[6:0];
                  if (is_vop_c) vop <= pend_byte[6:0];
`ifdef PCD8544_RX_ERRCHK_EN
                  if ((is_y_c && !y_ok_c) || (is_x_c && !x_ok_c) || undef_c) err_cmd <= 1'b1;
`endif
               end
            end
         end
      end
   end

   // Display RAM: contents are not reset
   always_ff @(posedge clk) begin
      if (we_c) ram[wr_addr_c] <= pend_byte;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_data <= '0;
      else if (32'(rd_addr) < DEPTH) rd_data <= ram[rd_addr];
      else rd_data <= '0;
   end

endmodule
